instr_fetch_loader: RTL and testbench
=====================================

// Module: instr_fetch_loader
// PURPOSE
//   Instruction-fetch stage directly upstream of the single-cycle datapath (PC/Control/Registradores/ALU/Memory).
//   Accepts the program as an ASCII '0'/'1' character stream, one 32-char line per instruction.
//   Assembles each line into a 32-bit word and stores it in a local instruction RAM.
//   Then serves instrucao/linha to PC, advancing sequentially or redirecting on branch (line/sum).
// PARAMETERS
//   DEPTH   64  instruction RAM entries (max program length)
//   INST_W  32  instruction width; also characters per line
//   LINE_W  12  width of linha/sum (matches datapath word)
// PORTS
//   clock       in   1       single clock; all state on rising edge
//   reset       in   1       asynchronous, active-high
//   char_valid  in   1       loader stream: character present
//   char_data   in   8       ASCII character
//   char_last   in   1       qualifies final character of file
//   char_ready  out  1       loader accepts character (1 only in LOAD)
//   advance     in   1       one-cycle pulse: datapath finished current instruction
//   line        in   1       branch taken (from ALU)
//   sum         in   LINE_W  branch target, 1-based line number
//   instrucao   out  INST_W  current instruction to PC/Control
//   linha       out  LINE_W  current 1-based line number
//   inst_valid  out  1       instrucao/linha are valid
//   load_done   out  1       program loaded, fetch running or finished
//   eof         out  1       program ran off its end (testbench stops clocking)
//   error       out  1       malformed stream or overflow; sticky until reset
// BEHAVIOUR
//   Reset values: state=LOAD, count=0, bitcnt=0; char_ready=1 in LOAD; all other outputs 0.
//     RAM contents not cleared.
//   FSM states: LOAD, RUN, DONE, ERR.
//   LOAD: handshake = char_valid & char_ready.
//     '0'(0x30) / '1'(0x31): shift into word, MSB first; bitcnt++.
//       At bitcnt==INST_W, write RAM[count], count++, bitcnt=0, same cycle.
//     0x0A / 0x0D: accepted only when bitcnt==0, ignored; otherwise -> ERR.
//     Any other byte -> ERR.
//     32nd bit arriving with count==DEPTH -> ERR; no write.
//     char_last on handshake: process char first, then
//       bitcnt!=0 -> ERR; count==0 -> DONE (eof=1);
//       else -> RUN next cycle with linha=1, instrucao=RAM[0], inst_valid=1.
//   RUN: advance ignored except in RUN.
//     target = line ? sum : linha+1 (LINE_W+1 bits, no wrap).
//     On advance: target==0 or target>count -> DONE, inst_valid=0, eof=1.
//       Else linha<=target, instrucao<=RAM[target-1].
//     Latency is 1 clock; inst_valid stays 1 across the update.
//   DONE: holds eof=1 and last linha; only reset exits.
//   ERR: error=1, char_ready=0, inst_valid=0, eof=1 (so bench terminates); only reset exits.
//   load_done=1 in RUN and DONE.
//   Reset mid-LOAD or mid-RUN: immediately returns to reset values; next load starts at RAM[0].
// STRUCTURE
//   Package fetch_pkg: state enum {LOAD,RUN,DONE,ERR}, ASCII_0/ASCII_1/ASCII_LF/ASCII_CR,
//     INST_W, LINE_W.
//   Sub-module bit_assembler: character -> bit shift, bitcnt, word_done/bad_char strobes.
//   RAM, count and fetch FSM in top level; RAM is an inferred register array.
// TESTING
//   1. 3 lines of valid text, last on final '\n'
//      -> count=3; linha=1, instrucao=word0; 2 advances give linha 2, 3; 3rd advance -> eof=1, inst_valid=0.
//   2. 4-line program in RUN at linha=2; advance with line=1, sum=4
//      -> next cycle linha=4, instrucao=word3; advance with line=1, sum=1 -> linha=1.
//   3. Branch out of range: sum=0 or sum=5 with count=4 -> DONE, eof=1.
//   4. Byte 'x' or '\n' after 10 bits -> error=1, char_ready=0, eof=1.
//      char_last at bitcnt=31 -> error=1.
//   5. DEPTH+1 full lines -> error on 32nd bit of extra line; RAM[DEPTH-1] intact.
//   6. Reset asserted mid-load after 2 lines, then 1-line program
//      -> linha=1, instrucao=new word0, count=1; empty stream (only char_last on '\n') -> eof=1, load_done=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, ASCII codes and widths for the instruction fetch loader.
package fetch_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DONE, ERR} state_t;
  localparam int INST_W = 32;
  localparam int LINE_W = 12;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
endpackage

// File: rtl/bit_assembler.sv
// bit_assembler: shifts accepted '0'/'1' characters into a word and flags complete words and bad characters.
module bit_assembler
  import fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              take,
  input  logic [7:0]        char_data,
  output logic [INST_W-1:0] word,
  output logic              word_done,
  output logic              bad_char,
  output logic              partial
);
  localparam int BW = $clog2(INST_W);
  logic [INST_W-1:0] shift;
  logic [BW-1:0] bitcnt;
  logic is_bit, is_eol;
  always_comb begin
    is_bit = char_data == ASCII_0 || char_data == ASCII_1;
    is_eol = char_data == ASCII_LF || char_data == ASCII_CR;
    word = {shift[INST_W-2:0], char_data == ASCII_1};
    word_done = take && is_bit && bitcnt == BW'(INST_W-1);
    bad_char = take && !is_bit && !(is_eol && bitcnt == '0);
    // partial: a line is still open after this character is consumed
    partial = (take && is_bit) ? bitcnt != BW'(INST_W-1) : bitcnt != '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      shift <= '0;
      bitcnt <= '0;
    end else if (take && is_bit) begin
      shift <= word;
      bitcnt <= bitcnt + BW'(1);
    end
endmodule

// File: rtl/instr_fetch_loader.sv
// instr_fetch_loader: loads an ASCII bit-stream program into local RAM, then serves instructions
// sequentially or on branch to the single-cycle datapath.
module instr_fetch_loader
  import fetch_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  input  logic              char_last,
  output logic              char_ready,
  input  logic              advance,
  input  logic              line,
  input  logic [LINE_W-1:0] sum,
  output logic [INST_W-1:0] instrucao,
  output logic [LINE_W-1:0] linha,
  output logic              inst_valid,
  output logic              load_done,
  output logic              eof,
  output logic              error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_t state;
  logic [CW-1:0] count, count_nxt;
  logic [INST_W-1:0] ram [DEPTH];
  logic [INST_W-1:0] word;
  logic take, word_done, bad_char, partial, overflow, wr;
  logic [LINE_W:0] target;
  logic [AW-1:0] tidx;
  bit_assembler u_asm (
    .clock(clock),
    .reset(reset),
    .take(take),
    .char_data(char_data),
    .word(word),
    .word_done(word_done),
    .bad_char(bad_char),
    .partial(partial)
  );
  always_comb begin
    char_ready = state == LOAD;
    take = char_valid && char_ready;
    overflow = word_done && count == CW'(DEPTH);
    wr = word_done && !overflow;
    count_nxt = wr ? count + CW'(1) : count;
    // target is one bit wider than linha so linha+1 never wraps back into range
    target = line ? {1'b0, sum} : {1'b0, linha} + (LINE_W+1)'(1);
    tidx = AW'(target - (LINE_W+1)'(1));
  end
  always_ff @(posedge clock)
    if (wr) ram[count[AW-1:0]] <= word;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= LOAD;
      count <= '0;
      instrucao <= '0;
      linha <= '0;
      inst_valid <= 1'b0;
      load_done <= 1'b0;
      eof <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        LOAD: if (take) begin
          count <= count_nxt;
          if (bad_char || overflow || (char_last && partial)) begin
            state <= ERR;
            error <= 1'b1;
            eof <= 1'b1;
          end else if (char_last && count_nxt == '0) begin
            state <= DONE;
            eof <= 1'b1;
            load_done <= 1'b1;
          end else if (char_last) begin
            state <= RUN;
            load_done <= 1'b1;
            inst_valid <= 1'b1;
            linha <= LINE_W'(1);
            // a program whose only line ends on this character has not reached the RAM yet
            instrucao <= count == '0 ? word : ram[AW'(0)];
          end
        end
        RUN: if (advance) begin
          if (target == '0 || target > (LINE_W+1)'(count)) begin
            state <= DONE;
            inst_valid <= 1'b0;
            eof <= 1'b1;
          end else begin
            linha <= target[LINE_W-1:0];
            instrucao <= ram[tidx];
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_loader.sv
// tb_instr_fetch_loader: randomized scoreboard bench; a program-level model predicts each fetch output.
module tb_instr_fetch_loader;
  typedef struct packed {
    logic err, eof, iv, ld;
    logic [11:0] ln;
    logic [31:0] ins;
  } obs_t;
  logic clock = 0, reset = 1, char_valid = 0, char_last = 0, advance = 0, line = 0;
  logic [7:0] char_data = 0;
  logic [11:0] sum = 0, linha;
  logic [31:0] instrucao;
  logic char_ready, inst_valid, load_done, eof, error;
  int checks = 0, passed = 0;
  obs_t exp_q[$];
  obs_t got, want;
  logic [7:0] cq[$];
  logic [31:0] model[$];
  int cur;
  bit done;
  logic adv_seen = 0, prev_ld = 0, prev_err = 0;
  localparam obs_t ERR_OBS = {4'b1100, 12'd0, 32'd0};

  always #5 clock = ~clock;

  instr_fetch_loader dut (
    .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_last(char_last), .char_ready(char_ready), .advance(advance), .line(line),
    .sum(sum), .instrucao(instrucao), .linha(linha), .inst_valid(inst_valid),
    .load_done(load_done), .eof(eof), .error(error)
  );

  task automatic chk(input string name, input logic [63:0] g, input logic [63:0] w);
    checks++;
    if (g === w) passed++;
    else $display("FAIL %s: got %h, want %h", name, g, w);
  endtask

  // monitor: an output event is load completion, an error, or the cycle after an accepted advance
  always @(posedge clock) adv_seen <= advance && inst_valid && !reset;
  always @(negedge clock) begin
    if (!reset && ((load_done && !prev_ld) || (error && !prev_err) || adv_seen)) begin
      got = {error, eof, inst_valid, load_done, linha, instrucao};
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %h, want no event", got);
      end else begin
        want = exp_q.pop_front();
        chk("fetch_out", got, want);
      end
    end
    prev_ld = load_done && !reset;
    prev_err = error && !reset;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    int n = 0;
    while ($urandom_range(3) == 0) begin
      char_valid = 0;
      char_data = 8'($urandom);
      char_last = 1'($urandom);
      tick();
    end
    char_valid = 1;
    char_data = c;
    char_last = last;
    while (!char_ready && n < 20) begin
      tick();
      n++;
    end
    if (!char_ready) begin
      checks++;
      $display("FAIL char_ready_timeout: got 0, want 1");
    end else tick();
    char_valid = 0;
    char_last = 0;
  endtask

  task automatic add_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) cq.push_back(w[i] ? 8'h31 : 8'h30);
  endtask

  task automatic add_eol(input int s);
    if (s == 2 || s == 3) cq.push_back(8'h0D);
    if (s != 3) cq.push_back(8'h0A);
    if (s == 4) cq.push_back(8'h0A);
  endtask

  task automatic stream(input int push_idx, input obs_t e, input bit last_final);
    for (int i = 0; i < cq.size(); i++) begin
      if (i == push_idx) exp_q.push_back(e);
      send(cq[i], last_final && i == cq.size() - 1);
    end
    cq.delete();
  endtask

  task automatic load_prog(input int n, input bit final_eol);
    logic [31:0] w;
    obs_t e;
    model.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      model.push_back(w);
      add_bits(w, 32);
      if (i < n - 1 || final_eol) add_eol(int'($urandom_range(1, 4)));
    end
    if (n == 0) cq.push_back(8'h0A);
    done = model.size() == 0;
    cur = done ? 0 : 1;
    e = done ? {4'b0101, 12'd0, 32'd0} : {4'b0011, 12'd1, model[0]};
    stream(cq.size() - 1, e, 1);
  endtask

  task automatic adv(input bit br, input int s);
    int t = br ? s : cur + 1;
    if (t < 1 || t > model.size()) begin
      exp_q.push_back({4'b0101, 12'(cur), model[cur-1]});
      done = 1;
    end else begin
      cur = t;
      exp_q.push_back({4'b0011, 12'(cur), model[cur-1]});
    end
    advance = 1;
    line = br;
    sum = 12'(s);
    tick();
    advance = 0;
    line = 1'($urandom);
    sum = 12'($urandom);
    repeat ($urandom_range(2)) tick();
  endtask

  task automatic do_reset();
    tick();
    reset = 1;
    #1;
    chk("reset_outputs", {char_ready, error, eof, inst_valid, load_done, linha, instrucao}, {1'b1, 48'b0});
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    do_reset();
    load_prog(3, 1);
    adv(0, 0); adv(0, 0); adv(0, 0);
    advance = 1; tick(); advance = 0; tick();
    chk("done_hold", {eof, inst_valid, load_done, linha}, {3'b101, 12'd3});
    do_reset();
    load_prog(4, 1);
    adv(0, 0); adv(1, 4); adv(1, 1); adv(1, 0);
    do_reset();
    load_prog(4, 0);
    adv(1, 5);
    do_reset();
    add_bits($urandom, 10); cq.push_back(8'h78);
    stream(10, ERR_OBS, 0);
    chk("bad_x_ready", char_ready, 0);
    do_reset();
    add_bits($urandom, 10); cq.push_back(8'h0A);
    stream(10, ERR_OBS, 0);
    chk("bad_lf_ready", {char_ready, eof}, 2'b01);
    do_reset();
    add_bits($urandom, 31);
    stream(30, ERR_OBS, 1);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      add_bits($urandom, 32);
      add_eol(1);
    end
    add_bits($urandom, 32);
    stream(cq.size() - 1, ERR_OBS, 0);
    chk("overflow_state", {char_ready, eof, load_done}, 3'b010);
    do_reset();
    add_bits($urandom, 32); add_eol(1); add_bits($urandom, 32); add_eol(2); add_bits($urandom, 5);
    stream(-1, '0, 0);
    do_reset();
    load_prog(1, 1);
    adv(0, 0);
    do_reset();
    load_prog(3, 1);
    adv(0, 0);
    do_reset();
    load_prog(0, 1);
    chk("empty_done", {eof, load_done, inst_valid}, 3'b110);
    for (int k = 0; k < 6; k++) begin
      do_reset();
      load_prog(int'($urandom_range(1, 8)), 1'($urandom));
      for (int j = 0; j < 20 && !done; j++)
        adv($urandom_range(2) == 0, int'($urandom_range(0, model.size() + 1)));
    end
    repeat (5) tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
